// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   SIZE_*       : request size encodings on req_size
//   lsu_state_t  : control FSM states
//   access_fault : decides whether a request is rejected without touching memory
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        RESP     = 2'd3
    } lsu_state_t;

    // A request faults on an illegal size, a misaligned half/word, or a word
    // index beyond the end of the memory.
    function automatic logic access_fault(
        input logic [1:0]  size,
        input logic [31:0] address,
        input logic [31:0] mem_words
    );
        logic misaligned;
        misaligned = ((size == SIZE_HALF) && address[0]) ||
                     ((size == SIZE_WORD) && (address[1:0] != 2'b00));
        return (size == SIZE_ILL) || misaligned ||
               ({2'b00, address[31:2]} >= mem_words);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for sub-word accesses (purely combinational).
//   size, offset   : access size and byte offset within the word (address[1:0])
//   is_unsigned    : loads zero-extend when set, sign-extend otherwise
//   rdata          : word read from memory
//   wdata          : right-justified store data
//   load_ext       : selected lane, extended to 32 bits
//   store_merged   : rdata with the store lane replaced by wdata's low bits
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] store_merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        byte_lane    = rdata[{offset, 3'b000} +: 8];
        half_lane    = rdata[{offset[1], 4'b0000} +: 16];
        load_ext     = rdata;
        store_merged = wdata;
        case (size)
            SIZE_BYTE: begin
                load_ext = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
                store_merged = rdata;
                store_merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_ext = {{16{~is_unsigned & half_lane[15]}}, half_lane};
                store_merged = rdata;
                store_merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-wide data memory without byte
// enables. Sub-word stores become read-modify-write sequences.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   req_*                 : valid/ready request (accepted only in IDLE)
//   resp_*                : valid/ready response, held stable until accepted
//   mem_we/address/wdata  : memory write port and word index
//   mem_rdata             : combinational read of mem_address
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_WORDS_W = MEM_WORDS;

    lsu_state_t  state, next_state;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic [31:0] load_ext;
    logic [31:0] store_merged;
    logic        accept;
    logic        fault;

    assign accept = (state == IDLE) && req_valid;
    assign fault  = access_fault(req_size, req_address, MEM_WORDS_W);

    lsu_align u_align (
        .size         (size_q),
        .offset       (offset_q),
        .is_unsigned  (unsigned_q),
        .rdata        (mem_rdata),
        .wdata        (wdata_q),
        .load_ext     (load_ext),
        .store_merged (store_merged)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (req_valid) next_state = fault ? RESP : ACCESS;
            // Sub-word stores need a second cycle to write the merged word.
            ACCESS:   next_state = (write_q && size_q != SIZE_WORD) ? MERGE_WR : RESP;
            MERGE_WR: next_state = RESP;
            RESP:     if (resp_ready) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        // Gating by reset drops a pending RMW write in the very cycle reset rises.
        mem_we     = !reset &&
                     (((state == ACCESS) && write_q && (size_q == SIZE_WORD)) ||
                      (state == MERGE_WR));
        mem_wdata  = (state == MERGE_WR) ? merged_q : wdata_q;
    end

    // Request latches, merge buffer and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_q     <= 1'b0;
            size_q      <= SIZE_BYTE;
            unsigned_q  <= 1'b0;
            offset_q    <= 2'b00;
            wdata_q     <= '0;
            merged_q    <= '0;
            resp_rdata  <= '0;
            resp_fault  <= 1'b0;
            mem_address <= '0;
        end else begin
            if (accept) begin
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                offset_q   <= req_address[1:0];
                wdata_q    <= req_wdata;
                resp_rdata <= '0;
                resp_fault <= fault;
                // A faulting request leaves the memory address untouched.
                if (!fault) mem_address <= {2'b00, req_address[31:2]};
            end
            if (state == ACCESS) begin
                if (!write_q) resp_rdata <= load_ext;
                else          merged_q   <= store_merged;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:31];
    int checks = 0;
    int passes = 0;

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_address  (req_address),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_we       (mem_we),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural data memory: combinational read, write on rising edge.
    assign mem_rdata = (mem_address < 32) ? mem[mem_address[4:0]] : 32'h0;
    always @(posedge clock) begin
        if (mem_we && mem_address < 32) mem[mem_address[4:0]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One transaction: drive, count cycles to resp_valid and mem_we cycles,
    // optionally stall the response, then release it.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic exp_fault,
                          input logic [31:0] exp_rdata, input int exp_we, input int hold);
        int lat;
        int we;
        logic got;
        @(negedge clock);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_address  = addr;
        req_wdata    = wdata;
        resp_ready   = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0;
        we  = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clock);
            lat++;
            if (mem_we) we++;
            if (resp_valid) got = 1'b1;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " fault"}, 32'(resp_fault), 32'(exp_fault));
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " mem_we cycles"}, 32'(we), 32'(exp_we));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({tag, " hold resp_valid"}, 32'(resp_valid), 32'd1);
            check({tag, " hold rdata"}, resp_rdata, exp_rdata);
            check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        @(negedge clock);
        check({tag, " released resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " released req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_address  = 32'h0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset resp_fault", 32'(resp_fault), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_address", mem_address, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Word store then load.
        do_req("sw 0x8", 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1, 0);
        check("mem[2] after sw", mem[2], 32'hDEADBEEF);
        do_req("lw 0x8", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0, 0);

        // Byte store via read-modify-write; upper wdata bits must be ignored.
        do_req("sb 0x9", 1'b1, 2'b00, 1'b0, 32'h9, 32'hABCDEF12, 3, 1'b0, 32'h0, 1, 0);
        check("mem[2] after sb", mem[2], 32'hDEAD12EF);

        // Sub-word loads with both extensions.
        do_req("lb 0xB",  1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 2, 1'b0, 32'hFFFFFFDE, 0, 0);
        do_req("lbu 0xB", 1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 2, 1'b0, 32'h000000DE, 0, 0);
        do_req("lh 0xA",  1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 2, 1'b0, 32'hFFFFDEAD, 0, 0);
        do_req("lhu 0x8", 1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 2, 1'b0, 32'h000012EF, 0, 0);

        // Upper-half store into word 0, then loads from it.
        do_req("sh 0x2", 1'b1, 2'b01, 1'b0, 32'h2, 32'h12348001, 3, 1'b0, 32'h0, 1, 0);
        check("mem[0] after sh", mem[0], 32'h80010000);
        do_req("lh 0x2",  1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 2, 1'b0, 32'hFFFF8001, 0, 0);
        do_req("lhu 0x2", 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 2, 1'b0, 32'h00008001, 0, 0);
        do_req("lbu 0x3", 1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 2, 1'b0, 32'h00000080, 0, 0);

        // Faults: misaligned, illegal size, out of range.
        do_req("lw 0x6 fault",   1'b0, 2'b10, 1'b0, 32'h6,  32'h0,        1, 1'b1, 32'h0, 0, 0);
        do_req("sh 0x3 fault",   1'b1, 2'b01, 1'b0, 32'h3,  32'hFFFFFFFF, 1, 1'b1, 32'h0, 0, 0);
        do_req("size11 fault",   1'b0, 2'b11, 1'b0, 32'h0,  32'h0,        1, 1'b1, 32'h0, 0, 0);
        do_req("lw 0x80 fault",  1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        1, 1'b1, 32'h0, 0, 0);
        do_req("sw 0x80 fault",  1'b1, 2'b10, 1'b0, 32'h80, 32'h55555555, 1, 1'b1, 32'h0, 0, 0);
        check("mem[2] after faults", mem[2], 32'hDEAD12EF);
        check("mem[0] after faults", mem[0], 32'h80010000);

        // Response back-pressure.
        do_req("lw 0x8 stall", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 2, 1'b0, 32'hDEAD12EF, 0, 5);

        // Reset in the middle of a sub-word store's write cycle.
        @(negedge clock);
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_address  = 32'h9;
        req_wdata    = 32'h34;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        #1;
        check("merge cycle mem_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("reset in merge mem_we", 32'(mem_we), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("post-reset req_ready", 32'(req_ready), 32'd1);
        check("post-reset resp_valid", 32'(resp_valid), 32'd0);
        check("post-reset resp_rdata", resp_rdata, 32'h0);
        check("post-reset resp_fault", 32'(resp_fault), 32'd0);
        check("post-reset mem_we", 32'(mem_we), 32'd0);
        check("post-reset mem_address", mem_address, 32'h0);
        check("mem[2] after dropped sb", mem[2], 32'hDEAD12EF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
